// File: rtl/cocotb_param_streamer_pkg.sv
// Shared types and header layout for the parameter streamer.
// Build option: define PARAM_STREAM_CSUM_EN to append an XOR checksum word to every stream.
package cocotb_param_streamer_pkg;

    // Width field size, also reused for the slot-index field of the header
    localparam int unsigned WidthFieldW = 8;
    localparam int unsigned HdrWidthLsb = 0;
    localparam int unsigned HdrIndexLsb = 8;
    localparam int unsigned HdrW        = 16;

`ifdef PARAM_STREAM_CSUM_EN
    typedef enum logic [1:0] {StIdle, StHdr, StData, StCsum} state_e;
`else
    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;
`endif

    // Low 16 bits of a header word: {slot index, effective width}
    function automatic logic [HdrW-1:0] make_hdr(input logic [WidthFieldW-1:0] width,
                                                 input logic [WidthFieldW-1:0] idx);
        logic [HdrW-1:0] r;
        r = '0;
        r[HdrWidthLsb +: WidthFieldW] = width;
        r[HdrIndexLsb +: WidthFieldW] = idx;
        return r;
    endfunction

endpackage

// File: rtl/cocotb_param_slicer.sv
// Combinational extraction of data word k of one parameter slot, LSB-first,
// with every bit at or above the slot's effective width forced to zero.
module cocotb_param_slicer
    import cocotb_param_streamer_pkg::*;
#(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned MAX_PARAM_W = 128
) (
    input  logic [MAX_PARAM_W-1:0] slot_data,
    input  logic [WidthFieldW-1:0] width,
    input  logic [7:0]             word_idx,
    output logic [WORD_W-1:0]      word
);

    // Padding keeps the shifted window in range when a word straddles the top of the slot
    logic [MAX_PARAM_W+WORD_W-1:0] padded;
    logic [MAX_PARAM_W+WORD_W-1:0] shifted;
    int unsigned                   base;

    // Shift the requested word down to bit 0, then mask bits beyond the slot width
    always_comb begin
        base    = 32'(word_idx) * WORD_W;
        padded  = {{WORD_W{1'b0}}, slot_data};
        shifted = padded >> base;
        word    = '0;
        for (int unsigned b = 0; b < WORD_W; b++) begin
            word[b] = shifted[b] & ((base + b) < 32'(width));
        end
    end

endmodule

// File: rtl/cocotb_param_streamer.sv
// Streams a latched table of variable-width parameters as a header word plus
// ceil(width/WORD_W) data words per slot over a valid/ready interface.
// Build option: PARAM_STREAM_CSUM_EN appends an XOR checksum word carrying out_last.
module cocotb_param_streamer
    import cocotb_param_streamer_pkg::*;
#(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned NUM_PARAMS  = 4,
    parameter int unsigned MAX_PARAM_W = 128
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [NUM_PARAMS*MAX_PARAM_W-1:0] param_data,
    input  logic [NUM_PARAMS*8-1:0]           param_width,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WORD_W-1:0]                 out_data,
    output logic                              out_last,
    output logic                              busy
);

    localparam int unsigned SlotW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
    localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_PARAMS - 1);

    state_e                 state_q;
    logic [SlotW-1:0]       slot_q;
    logic [7:0]             word_q;
    logic                   out_valid_q;
    logic [WORD_W-1:0]      out_data_q;
    logic                   out_last_q;
    logic                   busy_q;
    logic [MAX_PARAM_W-1:0] data_q  [NUM_PARAMS];
    logic [WidthFieldW-1:0] width_q [NUM_PARAMS];
`ifdef PARAM_STREAM_CSUM_EN
    logic [WORD_W-1:0]      csum_q;
    logic [WORD_W-1:0]      csum_nxt;
`endif

    logic                   handshake;
    logic [WidthFieldW-1:0] cur_w;
    int unsigned            cur_nwords;
    logic [7:0]             k_next;
    logic                   go_data;
    logic                   more_slots;
    logic [SlotW-1:0]       nxt_slot;
    logic [WidthFieldW-1:0] nxt_w;
    logic                   data_last;
    logic                   hdr_last;
    logic [WidthFieldW-1:0] start_w;
    logic                   start_last;
    logic [WORD_W-1:0]      slice_word;

    function automatic logic [WidthFieldW-1:0] clamp_w(input logic [WidthFieldW-1:0] w);
        if (32'(w) > MAX_PARAM_W) return WidthFieldW'(MAX_PARAM_W);
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] hdr_word(input logic [WidthFieldW-1:0] w,
                                                   input logic [SlotW-1:0] idx);
        logic [WORD_W-1:0] r;
        r = '0;
        r[HdrW-1:0] = make_hdr(w, 8'(idx));
        return r;
    endfunction

    // Decide what the word after the current one is and whether it ends the stream
    always_comb begin
        handshake  = out_valid_q && out_ready;
        cur_w      = width_q[slot_q];
        cur_nwords = (32'(cur_w) + WORD_W - 1) / WORD_W;
        k_next     = (state_q == StHdr) ? 8'd0 : word_q + 8'd1;
        go_data    = (state_q == StHdr) ? (cur_w != '0) : (32'(k_next) < cur_nwords);
        more_slots = (slot_q != LastSlot);
        nxt_slot   = more_slots ? slot_q + SlotW'(1) : slot_q;
        nxt_w      = width_q[nxt_slot];
        start_w    = clamp_w(param_width[WidthFieldW-1:0]);
`ifdef PARAM_STREAM_CSUM_EN
        csum_nxt   = csum_q ^ out_data_q;
        data_last  = 1'b0;
        hdr_last   = 1'b0;
        start_last = 1'b0;
`else
        data_last  = !more_slots && (32'(k_next) + 1 == cur_nwords);
        hdr_last   = (nxt_slot == LastSlot) && (nxt_w == '0);
        start_last = (LastSlot == '0) && (start_w == '0);
`endif
    end

    cocotb_param_slicer #(
        .WORD_W      (WORD_W),
        .MAX_PARAM_W (MAX_PARAM_W)
    ) u_slicer (
        .slot_data (data_q[slot_q]),
        .width     (cur_w),
        .word_idx  (k_next),
        .word      (slice_word)
    );

    // Stream FSM; every output is registered and only moves on a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PARAM_STREAM_CSUM_EN
            csum_q      <= '0;
`endif
            for (int i = 0; i < NUM_PARAMS; i++) begin
                data_q[i]  <= '0;
                width_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int i = 0; i < NUM_PARAMS; i++) begin
                            data_q[i]  <= param_data[i*MAX_PARAM_W +: MAX_PARAM_W];
                            width_q[i] <= clamp_w(param_width[i*8 +: 8]);
                        end
                        state_q     <= StHdr;
                        slot_q      <= '0;
                        word_q      <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= hdr_word(start_w, '0);
                        out_last_q  <= start_last;
                        busy_q      <= 1'b1;
`ifdef PARAM_STREAM_CSUM_EN
                        csum_q      <= '0;
`endif
                    end
                end
                StHdr, StData: begin
                    if (handshake) begin
`ifdef PARAM_STREAM_CSUM_EN
                        csum_q <= csum_nxt;
`endif
                        if (go_data) begin
                            state_q    <= StData;
                            word_q     <= k_next;
                            out_data_q <= slice_word;
                            out_last_q <= data_last;
                        end else if (more_slots) begin
                            state_q    <= StHdr;
                            slot_q     <= nxt_slot;
                            word_q     <= '0;
                            out_data_q <= hdr_word(nxt_w, nxt_slot);
                            out_last_q <= hdr_last;
                        end else begin
`ifdef PARAM_STREAM_CSUM_EN
                            state_q    <= StCsum;
                            out_data_q <= csum_nxt;
                            out_last_q <= 1'b1;
`else
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
`endif
                        end
                    end
                end
`ifdef PARAM_STREAM_CSUM_EN
                StCsum: begin
                    if (handshake) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
